// File: rtl/race_pkg.sv
// Shared encodings for the race sequencer: game phases, winner codes and the menu StartGame state.
package race_pkg;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_COUNTDOWN = 3'd1,
        PH_RACE      = 3'd2,
        PH_RESULT    = 3'd3,
        PH_RETURN    = 3'd4
    } race_phase_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_TIE  = 2'd3;

    localparam logic [2:0] MENU_START_GAME = 3'd1;

    // A false start hands the race to the other player; a double false start has no winner.
    function automatic logic [1:0] false_start_winner(input logic [1:0] fs_bits);
        logic [1:0] w;
        w = WIN_NONE;
        if (fs_bits == 2'b01)
            w = WIN_P2;
        else if (fs_bits == 2'b10)
            w = WIN_P1;
        return w;
    endfunction

endpackage

// File: rtl/race_sequencer_tick_divider.sv
// Free-running tick generator: one-cycle pulse every DIV clk cycles, restarted by clear.
module tick_divider #(
    parameter int DIV = 65_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || cnt == W'(DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    // Decoded from the count so the tick lands exactly DIV cycles after clear.
    assign tick = !clear && (cnt == W'(DIV - 1));

endmodule

// File: rtl/race_sequencer.sv
// Race game-phase controller: countdown, timed race, winner decision, result hold, menu return.
// Optional false-start detection during the countdown is enabled by defining RACE_FALSE_START_EN.
module race_sequencer #(
    parameter int SEC_CYCLES     = 65_000_000,
    parameter int MS_CYCLES      = 65_000,
    parameter int COUNT_FROM     = 3,
    parameter int RESULT_SECONDS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  menu_state,
    input  logic        p1_gas,
    input  logic        p2_gas,
    input  logic        p1_finish,
    input  logic        p2_finish,
    input  logic        esc,
    output logic [2:0]  race_phase,
    output logic [1:0]  countdown_value,
    output logic        race_active,
    output logic [15:0] race_time_ms,
    output logic [1:0]  winner,
    output logic [1:0]  false_start,
    output logic        back_to_main_menu_flag
);

    import race_pkg::*;

    localparam int RS_W = $clog2(RESULT_SECONDS + 1);

    race_phase_t     state;
    logic [2:0]      prev_menu;
    logic [RS_W-1:0] result_secs;
    logic            sec_tick;
    logic            ms_tick;
    logic            sec_clear;
    logic            ms_clear;
    logic            start_edge;
    logic [1:0]      fs_hit;

`ifdef RACE_FALSE_START_EN
    assign fs_hit = (state == PH_COUNTDOWN) ? {p2_gas, p1_gas} : 2'b00;
`else
    logic unused_gas;
    assign unused_gas = p1_gas ^ p2_gas;
    assign fs_hit     = 2'b00;
`endif

    // Dividers are held in reset outside the phases that time with them, so each entry starts fresh.
    assign sec_clear  = (state != PH_COUNTDOWN && state != PH_RESULT) || (fs_hit != 2'b00);
    assign ms_clear   = (state != PH_RACE);
    assign start_edge = (menu_state == MENU_START_GAME) && (prev_menu != MENU_START_GAME);
    assign race_phase = state;

    tick_divider #(.DIV(SEC_CYCLES)) u_sec_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (sec_clear),
        .tick  (sec_tick)
    );

    tick_divider #(.DIV(MS_CYCLES)) u_ms_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (ms_clear),
        .tick  (ms_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= PH_IDLE;
            prev_menu              <= 3'd0;
            result_secs            <= '0;
            countdown_value        <= 2'd0;
            race_active            <= 1'b0;
            race_time_ms           <= 16'd0;
            winner                 <= WIN_NONE;
            false_start            <= 2'b00;
            back_to_main_menu_flag <= 1'b0;
        end else begin
            prev_menu              <= menu_state;
            back_to_main_menu_flag <= 1'b0;
            case (state)
                PH_IDLE: begin
                    race_active <= 1'b0;
                    if (start_edge) begin
                        winner          <= WIN_NONE;
                        false_start     <= 2'b00;
                        race_time_ms    <= 16'd0;
                        countdown_value <= 2'(COUNT_FROM);
                        state           <= PH_COUNTDOWN;
                    end
                end
                PH_COUNTDOWN: begin
                    if (esc) begin
                        winner                 <= WIN_NONE;
                        back_to_main_menu_flag <= 1'b1;
                        state                  <= PH_RETURN;
                    end else if (fs_hit != 2'b00) begin
                        false_start <= fs_hit;
                        winner      <= false_start_winner(fs_hit);
                        result_secs <= '0;
                        state       <= PH_RESULT;
                    end else if (sec_tick) begin
                        if (countdown_value == 2'd1) begin
                            countdown_value <= 2'd0;
                            race_active     <= 1'b1;
                            state           <= PH_RACE;
                        end else begin
                            countdown_value <= countdown_value - 2'd1;
                        end
                    end
                end
                // Abort beats a finish, and a finish freezes the timer on the cycle it arrives.
                PH_RACE: begin
                    if (esc) begin
                        winner                 <= WIN_NONE;
                        race_active            <= 1'b0;
                        back_to_main_menu_flag <= 1'b1;
                        state                  <= PH_RETURN;
                    end else if (p1_finish || p2_finish) begin
                        winner      <= {p2_finish, p1_finish};
                        race_active <= 1'b0;
                        result_secs <= '0;
                        state       <= PH_RESULT;
                    end else if (ms_tick) begin
                        if (race_time_ms == 16'hFFFE) begin
                            race_time_ms <= 16'hFFFF;
                            winner       <= WIN_NONE;
                            race_active  <= 1'b0;
                            result_secs  <= '0;
                            state        <= PH_RESULT;
                        end else if (race_time_ms != 16'hFFFF) begin
                            race_time_ms <= race_time_ms + 16'd1;
                        end
                    end
                end
                PH_RESULT: begin
                    if (esc || (sec_tick && result_secs == RS_W'(RESULT_SECONDS - 1))) begin
                        back_to_main_menu_flag <= 1'b1;
                        state                  <= PH_RETURN;
                    end else if (sec_tick) begin
                        result_secs <= result_secs + RS_W'(1);
                    end
                end
                PH_RETURN: begin
                    state <= PH_IDLE;
                end
                default: begin
                    race_active <= 1'b0;
                    state       <= PH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_race_sequencer.sv
// Randomized self-checking bench for race_sequencer: expectations come from a timeline model
// (cycle offsets since each phase entry), honouring RACE_FALSE_START_EN when it is defined.
module tb_race_sequencer;

    localparam int SEC = 10;
    localparam int MS  = 2;
    localparam int CNT = 3;
    localparam int RES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  menu_state;
    logic        p1_gas, p2_gas, p1_finish, p2_finish, esc;
    logic [2:0]  race_phase;
    logic [1:0]  countdown_value;
    logic        race_active;
    logic [15:0] race_time_ms;
    logic [1:0]  winner;
    logic [1:0]  false_start;
    logic        back_to_main_menu_flag;

    int vectors = 0;
    int errors  = 0;
    int e_cd, e_time, e_win, e_fs;

    always #5 clk = ~clk;

    race_sequencer #(
        .SEC_CYCLES     (SEC),
        .MS_CYCLES      (MS),
        .COUNT_FROM     (CNT),
        .RESULT_SECONDS (RES)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .menu_state             (menu_state),
        .p1_gas                 (p1_gas),
        .p2_gas                 (p2_gas),
        .p1_finish              (p1_finish),
        .p2_finish              (p2_finish),
        .esc                    (esc),
        .race_phase             (race_phase),
        .countdown_value        (countdown_value),
        .race_active            (race_active),
        .race_time_ms           (race_time_ms),
        .winner                 (winner),
        .false_start            (false_start),
        .back_to_main_menu_flag (back_to_main_menu_flag)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkState(input string tag, input int ph, input int flag);
        checkOutput({tag, ".phase"},       int'(race_phase),             ph);
        checkOutput({tag, ".countdown"},   int'(countdown_value),        e_cd);
        checkOutput({tag, ".active"},      int'(race_active),            (ph == 2) ? 1 : 0);
        checkOutput({tag, ".time"},        int'(race_time_ms),           e_time);
        checkOutput({tag, ".winner"},      int'(winner),                 e_win);
        checkOutput({tag, ".false_start"}, int'(false_start),            e_fs);
        checkOutput({tag, ".flag"},        int'(back_to_main_menu_flag), flag);
    endtask

    task automatic applyStimulus(input logic g1, input logic g2, input logic f1, input logic f2,
                                 input logic e);
        p1_gas    = g1;
        p2_gas    = g2;
        p1_finish = f1;
        p2_finish = f2;
        esc       = e;
    endtask

    task automatic stepCycle();
        @(negedge clk);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic finishReturn();
        checkState("return", 4, 1);
        stepCycle();
        for (int o = 0; o < 4; o++) begin
            checkState("idle_hold", 0, 0);
            stepCycle();
        end
        menu_state = 3'd0;
        stepCycle();
        checkState("idle", 0, 0);
    endtask

    task automatic doResult();
        int esc_at;
        esc_at = (int'($urandom_range(0, 3)) == 0) ? int'($urandom_range(0, RES * SEC - 1)) : -1;
        for (int o = 0; o < RES * SEC; o++) begin
            checkState("result", 3, 0);
            applyStimulus(rbit(), rbit(), rbit(), rbit(), (o == esc_at) ? 1'b1 : 1'b0);
            stepCycle();
            if (o == esc_at) break;
        end
        applyStimulus(0, 0, 0, 0, 0);
        finishReturn();
    endtask

    // mode: 0 P1 finish, 1 P2 finish, 2 tie, 3 esc alone, 4 esc with P2 finish
    task automatic doRace(input int mode, input int k);
        for (int o = 0; o < k; o++) begin
            e_time = o / MS;
            checkState("race", 2, 0);
            if (o == k - 1)
                applyStimulus(rbit(), rbit(), (mode == 0 || mode == 2) ? 1'b1 : 1'b0,
                              (mode == 1 || mode == 2 || mode == 4) ? 1'b1 : 1'b0,
                              (mode >= 3) ? 1'b1 : 1'b0);
            else
                applyStimulus(rbit(), rbit(), 0, 0, 0);
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 0);
        e_time = (k - 1) / MS;
        if (mode >= 3) begin
            e_win = 0;
            finishReturn();
        end else begin
            e_win = (mode == 0) ? 1 : (mode == 1) ? 2 : 3;
            doResult();
        end
    endtask

    task automatic doCountdown(input int fs_at, input logic [1:0] fs_bits, output bit fs_taken);
        fs_taken   = 1'b0;
        menu_state = 3'd1;
        applyStimulus(0, 0, 0, 0, 0);
        stepCycle();
        e_win  = 0;
        e_fs   = 0;
        e_time = 0;
        for (int o = 0; o < CNT * SEC; o++) begin
            e_cd = CNT - o / SEC;
            checkState("countdown", 1, 0);
`ifdef RACE_FALSE_START_EN
            applyStimulus((o == fs_at) ? fs_bits[0] : 1'b0, (o == fs_at) ? fs_bits[1] : 1'b0,
                          rbit(), rbit(), 0);
`else
            applyStimulus((o == fs_at) ? fs_bits[0] : rbit(), (o == fs_at) ? fs_bits[1] : rbit(),
                          rbit(), rbit(), 0);
`endif
            stepCycle();
`ifdef RACE_FALSE_START_EN
            if (o == fs_at && fs_bits != 2'b00) begin
                applyStimulus(0, 0, 0, 0, 0);
                e_fs     = int'(fs_bits);
                e_win    = (fs_bits == 2'b11) ? 0 : (fs_bits == 2'b10) ? 1 : 2;
                fs_taken = 1'b1;
                return;
            end
`endif
        end
        applyStimulus(0, 0, 0, 0, 0);
        e_cd = 0;
    endtask

    initial begin
        bit fs;
        rst_n      = 1'b0;
        menu_state = 3'd0;
        applyStimulus(0, 0, 0, 0, 0);
        e_cd = 0; e_time = 0; e_win = 0; e_fs = 0;
        repeat (2) stepCycle();
        checkState("reset", 0, 0);
        rst_n = 1'b1;
        stepCycle();
        checkState("idle_after_reset", 0, 0);

        doCountdown(-1, 2'b00, fs);
        doRace(0, 21);
        doCountdown(-1, 2'b00, fs);
        doRace(2, 7);
        doCountdown(-1, 2'b00, fs);
        doRace(4, 13);
        doCountdown(-1, 2'b00, fs);
        doRace(3, 1);

        doCountdown(12, 2'b10, fs);
        if (fs) doResult();
        else    doRace(0, 5);

        repeat (10) begin
            int fs_at;
            logic [1:0] bits;
            fs_at = (int'($urandom_range(0, 3)) == 0) ? int'($urandom_range(0, CNT * SEC - 1)) : -1;
            bits  = 2'($urandom_range(1, 3));
            doCountdown(fs_at, bits, fs);
            if (fs) doResult();
            else    doRace(int'($urandom_range(0, 4)), int'($urandom_range(1, 45)));
        end

        doCountdown(-1, 2'b00, fs);
        for (int o = 0; o < 8; o++) begin
            e_time = o / MS;
            checkState("race_pre_reset", 2, 0);
            applyStimulus(rbit(), rbit(), 0, 0, 0);
            stepCycle();
        end
        #2 rst_n = 1'b0;
        #1;
        e_cd = 0; e_time = 0; e_win = 0; e_fs = 0;
        checkState("async_reset", 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        stepCycle();
        checkState("held_reset", 0, 0);
        rst_n = 1'b1;
        doCountdown(-1, 2'b00, fs);
        doRace(1, 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/race_sequencer.md
# race_sequencer

Game-phase controller that runs a race once the main-menu FSM enters its StartGame state: 3-2-1 countdown, race timing, winner decision, result hold, then the one-cycle return request back to the menu. It consumes the menu's `menu_state` and drives the menu's `back_to_main_menu_flag`. It also supplies phase, countdown, timer and winner data to the drawing and HUD logic.

## Interface
- `SEC_CYCLES`, default 65_000_000: clk cycles per countdown/result second.
- `MS_CYCLES`, default 65_000: clk cycles per race-timer millisecond.
- `COUNT_FROM`, default 3: countdown start value, legal range 1..3.
- `RESULT_SECONDS`, default 5: seconds the result is held before returning.
- `clk`, in, 1: system clock, single domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `menu_state`, in, 3: menu FSM state. Value 1 means StartGame.
- `p1_gas`, `p2_gas`, in, 1 each: player throttle levels.
- `p1_finish`, `p2_finish`, in, 1 each: single-cycle finish-line pulses.
- `esc`, in, 1: abort request pulse.
- `race_phase`, out, 3: current phase encoding.
- `countdown_value`, out, 2: digit to display.
- `race_active`, out, 1: high only in RACE.
- `race_time_ms`, out, 16: elapsed race time.
- `winner`, out, 2: 0 none/abort, 1 P1, 2 P2, 3 tie.
- `false_start`, out, 2: bit0 P1, bit1 P2.
- `back_to_main_menu_flag`, out, 1: one-cycle return request.

## Operation
- States are IDLE=0, COUNTDOWN=1, RACE=2, RESULT=3, RETURN=4. `race_phase` equals the state code. Any other code goes to IDLE.
- **IDLE**
  - Stay here until a rising edge of (`menu_state`==1), detected against a registered previous `menu_state`.
  - On that edge, clear `winner`, `false_start` and `race_time_ms`, load `countdown_value`=COUNT_FROM, restart the second counter, and go to COUNTDOWN.
- **COUNTDOWN**
  - On each second tick, decrement `countdown_value`.
  - A tick while the value is 1 sets `countdown_value`=0, restarts the ms counter, and goes to RACE.
  - `esc` goes to RETURN with `winner`=0.
  - False-start rule is in Configuration.
- **RACE**
  - Each ms tick increments `race_time_ms`, saturating at 0xFFFF.
  - The first cycle with any finish pulse latches the winner and goes to RESULT: `winner`=1 if only `p1_finish`, 2 if only `p2_finish`, 3 if both in the same cycle.
  - `race_time_ms` freezes at its value in that cycle.
  - Reaching saturation goes to RESULT with `winner`=0.
  - `esc` goes to RETURN with `winner`=0.
  - If `esc` and a finish pulse occur in the same cycle, `esc` wins.
- **RESULT**
  - Restart the second counter on entry.
  - After RESULT_SECONDS ticks, or on `esc`, go to RETURN.
  - Finish pulses are ignored.
- **RETURN**
  - Assert `back_to_main_menu_flag` for exactly this one cycle, then go to IDLE.
- Finish pulses and gas inputs outside their active state are ignored.

## Timing
- All outputs are registered.
- Reset values: `race_phase`=0, `countdown_value`=0, `race_active`=0, `race_time_ms`=0, `winner`=0, `false_start`=0, `back_to_main_menu_flag`=0. The previous-`menu_state` register resets to 0.
- Countdown timing:
  - COUNTDOWN is entered 1 cycle after the StartGame edge is sampled.
  - The first decrement happens exactly SEC_CYCLES cycles after entry.
  - RACE is entered COUNT_FROM×SEC_CYCLES cycles after entry.
- The first `race_time_ms` increment happens MS_CYCLES cycles after RACE entry.
- Finish pulse sampled at edge N: `race_phase`=RESULT and `winner` are valid after edge N.
- `back_to_main_menu_flag` is high for 1 cycle. The menu FSM is in Main on the following cycle, so IDLE does not retrigger.
- Reset asserted mid-race returns everything to reset values immediately. No flag pulse is issued.

## Configuration
- `RACE_FALSE_START_EN` defined:
  - During COUNTDOWN, `p1_gas`/`p2_gas` high sets the matching `false_start` bit and goes to RESULT.
  - `winner` is the other player, or 0 if both players are set in the same cycle.
- Macro undefined:
  - Gas inputs are ignored in COUNTDOWN.
  - `false_start` is held at 0.

## Structure
- Shared package `race_pkg` holds:
  - state/phase localparams;
  - winner codes (NONE, P1, P2, TIE);
  - the menu StartGame constant (value 1).
- One sub-module, `tick_divider`:
  - parameter DIV;
  - `clk`, `rst_n`, `clear` in; `tick` out, a one-cycle pulse every DIV cycles after `clear`.
  - Instanced twice: second (SEC_CYCLES) and millisecond (MS_CYCLES).

## Test plan
Bench parameters: SEC_CYCLES=10, MS_CYCLES=2, COUNT_FROM=3, RESULT_SECONDS=2.
- Countdown: `menu_state` 0→1 → `countdown_value` 3,2,1 at 10-cycle spacing. `race_active`=1 exactly 30 cycles after COUNTDOWN entry.
- P1 wins: `p1_finish` pulse 20 cycles into RACE → `winner`=1, `race_time_ms`=10 frozen. RETURN 20 cycles later with a single-cycle `back_to_main_menu_flag`.
- Tie and esc priority:
  - both finish pulses in the same cycle → `winner`=3;
  - `esc` together with `p2_finish` → RETURN, `winner`=0.
- False start with macro defined: `p2_gas`=1 at countdown 2 → `false_start`=2'b10, `winner`=1, phase RESULT.
- Macro undefined: same stimulus → countdown continues and `false_start`=0.
- Reset and level trigger:
  - `rst_n` low mid-RACE → all outputs 0, phase IDLE;
  - `menu_state` held at 1 after reset release with previous=0 → one race starts;
  - `menu_state` held at 1 after RETURN → no retrigger.
